// File: rtl/operand_fetch_wb.sv
// Operand fetch and writeback stage around a combinational ALU: register file,
// registered ALU operands, result/flag writeback and a debug read port.
module operand_fetch_wb #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 8,
  parameter int NREGS  = 8,
  parameter int FLAG_W = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_rs1,
  input  logic [AW-1:0]     instr_rs2,
  input  logic              instr_imm_en,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_use_c,
  output logic [DATA_W-1:0] alu_R1,
  output logic [DATA_W-1:0] alu_R2,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              wb_done,
  output logic [FLAG_W-1:0] flags_q,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREGS];
  logic [AW-1:0]     rd_p0;
  logic              accept;
  logic              in_wb;
  logic              fwd1, fwd2;
  logic [DATA_W-1:0] r1_sel, r2_sel;
  logic              cin_sel;

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    wb_done     = 1'b0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = WB;
      end
      WB: begin
        instr_ready = 1'b1;
        wb_done     = 1'b1;
        state_nxt   = instr_valid ? EXEC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = instr_valid & instr_ready;
  assign in_wb  = (state == WB);

  // A source matching the instruction being written back this edge sees the
  // live ALU result; R0 is never a forwarding target.
  assign fwd1 = in_wb && (rd_p0 != '0) && (instr_rs1 == rd_p0);
  assign fwd2 = in_wb && (rd_p0 != '0) && (instr_rs2 == rd_p0);

  always_comb begin
    r1_sel  = fwd1 ? alu_out : regs[instr_rs1];
    r2_sel  = instr_imm_en ? instr_imm : (fwd2 ? alu_out : regs[instr_rs2]);
    cin_sel = 1'b0;
    if (instr_use_c) cin_sel = in_wb ? alu_flags[0] : flags_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_p0      <= '0;
      alu_R1     <= '0;
      alu_R2     <= '0;
      alu_opcode <= '0;
      alu_cin    <= 1'b0;
      flags_q    <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      // accept: operands are latched and held until the next accept
      if (accept) begin
        alu_R1     <= r1_sel;
        alu_R2     <= r2_sel;
        alu_opcode <= instr_op;
        alu_cin    <= cin_sel;
        rd_p0      <= instr_rd;
      end
      // writeback: result to rd (R0 discarded), flags always
      if (in_wb) begin
        if (rd_p0 != '0) regs[rd_p0] <= alu_out;
        flags_q <= alu_flags;
      end
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_operand_fetch_wb.sv
// Directed bench for operand_fetch_wb with a small add/subtract ALU stub.
module tb_operand_fetch_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  instr_op = '0;
  logic [2:0]  instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic        instr_imm_en = 1'b0;
  logic [15:0] instr_imm = '0;
  logic        instr_use_c = 1'b0;
  logic [15:0] alu_R1, alu_R2, alu_out;
  logic [7:0]  alu_opcode;
  logic        alu_cin;
  logic [3:0]  alu_flags;
  logic        wb_done;
  logic [3:0]  flags_q;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  operand_fetch_wb dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
    .instr_use_c(instr_use_c),
    .alu_R1(alu_R1), .alu_R2(alu_R2), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .wb_done(wb_done), .flags_q(flags_q),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU stub: 0x01 add with carry-in, 0x02 subtract; flags = {0,0,zero,carry}
  logic [16:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (alu_opcode)
      8'h01:   alu_wide = {1'b0, alu_R1} + {1'b0, alu_R2} + {16'd0, alu_cin};
      8'h02:   alu_wide = {1'b0, alu_R1} - {1'b0, alu_R2};
      default: alu_wide = '0;
    endcase
  end
  assign alu_out   = alu_wide[15:0];
  assign alu_flags = {2'b00, (alu_wide[15:0] == 16'd0), alu_wide[16]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction and returns one step after the accepting edge.
  task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm,
                       input logic use_c);
    int n;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_imm_en = imm_en; instr_imm = imm; instr_use_c = use_c;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 10) begin
      tick();
      n++;
    end
    check("ready_wait", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic read_dbg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  int wb_count;

  initial begin
    // reset state
    #12;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_wb", {31'd0, wb_done}, 32'd0);
    check("rst_flags", {28'd0, flags_q}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // reset in the middle of EXEC abandons the instruction
    issue(8'h01, 3'd3, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b0);
    check("exec_ready", {31'd0, instr_ready}, 32'd0);
    check("exec_R2", {16'd0, alu_R2}, 32'h1234);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("mid_rst_R2", {16'd0, alu_R2}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick(); tick(); tick();
    check("abandon_wb", {31'd0, wb_done}, 32'd0);
    check("abandon_flags", {28'd0, flags_q}, 32'd0);
    check("abandon_ready", {31'd0, instr_ready}, 32'd1);
    read_dbg("abandon_r3", 3'd3, 16'h0000);

    // dependent pair with wb_done timing
    issue(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 1'b0);
    check("a_R2", {16'd0, alu_R2}, 32'd5);
    check("a_wb_early", {31'd0, wb_done}, 32'd0);
    tick();
    check("a_wb_pulse", {31'd0, wb_done}, 32'd1);
    tick();
    check("a_wb_clear", {31'd0, wb_done}, 32'd0);
    read_dbg("a_r1", 3'd1, 16'h0005);
    issue(8'h01, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0003, 1'b0);
    check("b_R1", {16'd0, alu_R1}, 32'd5);
    check("b_R2", {16'd0, alu_R2}, 32'd3);
    tick();
    check("b_wb_pulse", {31'd0, wb_done}, 32'd1);
    tick();
    read_dbg("b_r2", 3'd2, 16'h0008);

    // back-to-back with operand and carry forwarding
    issue(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b0); tick(); tick();
    issue(8'h01, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0077, 1'b0); tick(); tick();
    read_dbg("pre_r4", 3'd4, 16'h0077);
    issue(8'h01, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b0);
    tick();
    issue(8'h01, 3'd5, 3'd4, 3'd0, 1'b1, 16'h0000, 1'b1);
    check("fwd_R1", {16'd0, alu_R1}, 32'h0000);
    check("fwd_cin", {31'd0, alu_cin}, 32'd1);
    check("a_carry", {28'd0, flags_q}, 32'h3);
    read_dbg("a_r4", 3'd4, 16'h0000);
    tick(); tick();
    read_dbg("fwd_r5", 3'd5, 16'h0001);

    // writes to R0 are dropped but flags update
    issue(8'h02, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0000, 1'b0);
    tick();
    check("r0_wb", {31'd0, wb_done}, 32'd1);
    tick();
    check("r0_flags", {31'd0, flags_q[1]}, 32'd1);
    read_dbg("r0_dbg", 3'd0, 16'h0000);
    issue(8'h01, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0055, 1'b0); tick(); tick();
    issue(8'h01, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0000, 1'b0);
    check("r0_reads_zero", {16'd0, alu_R1}, 32'd0);
    tick(); tick();

    // valid held high across three instructions
    instr_op = 8'h01; instr_rd = 3'd1; instr_rs1 = 3'd0; instr_rs2 = 3'd0;
    instr_imm_en = 1'b1; instr_imm = 16'h0010; instr_use_c = 1'b0;
    instr_valid = 1'b1;
    wb_count = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 0) begin instr_rd = 3'd2; instr_rs1 = 3'd1; instr_imm = 16'h0020; end
      if (k == 2) begin
        check("strm_R1_c2", {16'd0, alu_R1}, 32'h0010);
        instr_rd = 3'd3; instr_rs1 = 3'd2; instr_imm = 16'h0001;
      end
      if (k == 4) begin
        check("strm_R1_c3", {16'd0, alu_R1}, 32'h0030);
        instr_valid = 1'b0;
      end
      check($sformatf("strm_ready_%0d", k), {31'd0, instr_ready}, ((k % 2) == 1 || k == 6) ? 32'd1 : 32'd0);
      check($sformatf("strm_wb_%0d", k), {31'd0, wb_done}, ((k % 2) == 1) ? 32'd1 : 32'd0);
      if (wb_done) wb_count++;
    end
    check("strm_wb_count", wb_count, 32'd3);
    read_dbg("strm_r3", 3'd3, 16'h0031);

    // destination equal to both sources
    issue(8'h01, 3'd6, 3'd0, 3'd0, 1'b1, 16'h4000, 1'b0); tick(); tick();
    issue(8'h01, 3'd6, 3'd6, 3'd6, 1'b0, 16'h0000, 1'b0);
    check("self_R1", {16'd0, alu_R1}, 32'h4000);
    check("self_R2", {16'd0, alu_R2}, 32'h4000);
    tick(); tick();
    read_dbg("self_r6", 3'd6, 16'h8000);
    check("self_carry", {31'd0, flags_q[0]}, 32'd0);
    tick();
    check("idle_hold_R1", {16'd0, alu_R1}, 32'h4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
